// File: rtl/dot9_feeder_pkg.sv
// Shared word width, term count, index width and FSM encoding for the dot9 feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dot9_feeder_pkg;

    localparam int DOT9_WIDTH  = 32;
    localparam int DOT9_NTERMS = 9;
    localparam int IDX_W       = 4;
    localparam int RND_W       = 2;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_LOADC = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return i + {{(IDX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/dot9_feeder_if.sv
// Beat input and operand-set output bundle between the feeder, its source and the FMA.
// Latency: n/a (wires only).
// Backpressure: in_ready toward the source, op_ready from the FMA.
interface dot9_feeder_if
    import dot9_feeder_pkg::*;
#(
    parameter int WIDTH  = DOT9_WIDTH,
    parameter int NTERMS = DOT9_NTERMS
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_a;
    logic [WIDTH-1:0]         in_b;
    logic                     in_last;
    logic [RND_W-1:0]         in_rnd;
    logic [NTERMS*WIDTH-1:0]  op_a;
    logic [NTERMS*WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]         op_c;
    logic [RND_W-1:0]         op_rnd;
    logic [IDX_W-1:0]         op_count;
    logic                     op_valid;
    logic                     op_ready;

    modport master (
        output flush, in_valid, in_a, in_b, in_last, in_rnd, op_ready,
        input  in_ready, op_a, op_b, op_c, op_rnd, op_count, op_valid
    );

    modport slave (
        input  flush, in_valid, in_a, in_b, in_last, in_rnd, op_ready,
        output in_ready, op_a, op_b, op_c, op_rnd, op_count, op_valid
    );
endinterface

// File: rtl/dot9_operand_bank.sv
// NTERMS-slot A/B operand store with one write port and a zero-fill of all slots >= fill_from.
// Latency: write visible on the outputs the cycle after we/fill_en.
// Backpressure: none; always accepts writes.
module dot9_operand_bank
    import dot9_feeder_pkg::*;
#(
    parameter int WIDTH  = DOT9_WIDTH,
    parameter int NTERMS = DOT9_NTERMS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic                    fill_en,
    input  logic [IDX_W-1:0]        fill_from,
    output logic [NTERMS*WIDTH-1:0] bank_a,
    output logic [NTERMS*WIDTH-1:0] bank_b
);

    logic [NTERMS-1:0][WIDTH-1:0] a_q, a_d;
    logic [NTERMS-1:0][WIDTH-1:0] b_q, b_d;

    // Write and fill never target the same slot: fill_from is always idx+1.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        for (int k = 0; k < NTERMS; k++) begin
            if (we && idx == IDX_W'(k)) begin
                a_d[k] = a;
                b_d[k] = b;
            end
            if (fill_en && IDX_W'(k) >= fill_from) begin
                a_d[k] = '0;
                b_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign bank_a = a_q;
    assign bank_b = b_q;

endmodule

// File: rtl/dot9_feeder.sv
// Collects up to NTERMS A/B pair beats plus one C beat into a stable operand set for a dot-product FMA.
// Latency: op_valid rises 1 cycle after the C beat is accepted.
// Backpressure: in_ready low while a set is issued; the set holds until op_ready.
module dot9_feeder
    import dot9_feeder_pkg::*;
#(
    parameter int WIDTH  = DOT9_WIDTH,
    parameter int NTERMS = DOT9_NTERMS
) (
    input  logic          clk,
    input  logic          rst,
    dot9_feeder_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTERMS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   c_q, c_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic               bank_we;
    logic               fill_en;
    logic [IDX_W-1:0]   fill_from;

    // flush only matters while accepting beats; an issued set is never torn.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        c_d       = c_q;
        rnd_d     = rnd_q;
        bank_we   = 1'b0;
        fill_en   = 1'b0;
        fill_from = next_idx(idx_q);
        case (state_q)
            ST_LOAD: begin
                if (bus.flush) begin
                    idx_d = '0;
                end else if (bus.in_valid) begin
                    bank_we = 1'b1;
                    if (idx_q == LAST_IDX || bus.in_last) begin
                        fill_en = 1'b1;
                        count_d = next_idx(idx_q);
                        idx_d   = '0;
                        state_d = ST_LOADC;
                    end else begin
                        idx_d = next_idx(idx_q);
                    end
                end
            end
            ST_LOADC: begin
                if (bus.flush) begin
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end else if (bus.in_valid) begin
                    c_d     = bus.in_a;
                    rnd_d   = bus.in_rnd;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.op_ready) begin
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            count_q <= '0;
            c_q     <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            c_q     <= c_d;
            rnd_q   <= rnd_d;
        end
    end

    dot9_operand_bank #(
        .WIDTH  (WIDTH),
        .NTERMS (NTERMS)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .we        (bank_we),
        .idx       (idx_q),
        .a         (bus.in_a),
        .b         (bus.in_b),
        .fill_en   (fill_en),
        .fill_from (fill_from),
        .bank_a    (bus.op_a),
        .bank_b    (bus.op_b)
    );

    assign bus.in_ready = (state_q != ST_ISSUE);
    assign bus.op_valid = (state_q == ST_ISSUE);
    assign bus.op_c     = c_q;
    assign bus.op_rnd   = rnd_q;
    assign bus.op_count = count_q;

endmodule

// File: doc/dot9_feeder.md
DOT9_FEEDER -- requirements
Module: dot9_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the IEEE-754 word width, taken from the shared parameters include.
REQ-002 SHALL have parameter NTERMS, default 9, meaning the number of A*B product pairs per dot-product operation.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  synchronous abort of a partially loaded operation.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-008 SHALL have port in_a  input  WIDTH  A operand on pair beats; C operand on the C beat.
REQ-009 SHALL have port in_b  input  WIDTH  B operand on pair beats; ignored on the C beat.
REQ-010 SHALL have port in_last  input  1  marks the final pair beat of a short operation.
REQ-011 SHALL have port in_rnd  input  2  rounding mode, sampled on the C beat only.
REQ-012 SHALL have port op_a  output  NTERMS*WIDTH  A1..A9 packed; A(k+1) at [k*WIDTH +: WIDTH].
REQ-013 SHALL have port op_b  output  NTERMS*WIDTH  B1..B9 packed in the same order as op_a.
REQ-014 SHALL have port op_c  output  WIDTH  addend C.
REQ-015 SHALL have port op_rnd  output  2  latched rounding mode.
REQ-016 SHALL have port op_count  output  4  number of real (non-padded) pairs, 1..9.
REQ-017 SHALL have port op_valid  output  1  operand set complete and stable.
REQ-018 SHALL have port op_ready  input  1  the downstream dot-product FMA consumes the set when op_valid && op_ready.

Function
REQ-019 SHALL implement the FSM states LOAD, LOADC and ISSUE.
REQ-020 In LOAD, each accepted beat SHALL write in_a/in_b into slot idx and then increment idx.
REQ-021 LOAD SHALL go to LOADC when idx==8 is accepted or when in_last is accepted on any pair beat.
REQ-022 On the LOAD->LOADC transition, every slot above the last written slot SHALL be written with +0.0 (all zeros) in both A and B in the same cycle, and op_count SHALL be set to the last written idx+1.
REQ-023 in_last on slot 8 SHALL be redundant and SHALL have no additional effect.
REQ-024 In LOADC, an accepted beat SHALL latch in_a into op_c and in_rnd into op_rnd, then go to ISSUE.
REQ-025 In LOADC, in_last and in_b SHALL be ignored.
REQ-026 In ISSUE, op_valid SHALL be 1 and all op_* outputs SHALL hold stable until op_ready is sampled 1.
REQ-027 On handshake in ISSUE, the block SHALL go to LOAD with idx=0.
REQ-028 in_ready SHALL be 1 in LOAD and LOADC and 0 in ISSUE.
REQ-029 There SHALL be no bypass from ISSUE back to input acceptance.
REQ-030 op_valid SHALL rise in the cycle after the C beat is accepted, giving a latency of 1 cycle from the C beat.
REQ-031 The minimum operation period SHALL be (pairs+1) accept cycles + 1 ISSUE cycle.
REQ-032 flush in LOAD or LOADC SHALL return the block to LOAD with idx=0 and discard any beat presented in the same cycle.
REQ-033 flush in ISSUE SHALL be ignored, so an issued set is never torn.
REQ-034 When flush and in_valid are both 1, flush SHALL win.
REQ-035 Operand words SHALL be stored unmodified, with no unpacking or subnormal handling; NaN/Inf/subnormal inputs pass through bit-exact.

Reset
REQ-036 When rst is 1 at a clock edge, the state SHALL become LOAD, idx=0, op_valid=0, op_a/op_b/op_c=0, op_rnd=0 and op_count=0.
REQ-037 rst SHALL take priority over flush and over any handshake.
REQ-038 rst asserted mid-load or during ISSUE SHALL drop the set without emitting it.

Structure
REQ-039 WIDTH, NTERMS and the FSM state encodings SHALL reside in the shared parameters include, not locally.
REQ-040 The 9-slot A/B storage with zero-fill SHALL be a single sub-module, dot9_operand_bank, with write port (we, idx, a, b) and fill port (fill_en, fill_from).
REQ-041 The FSM and handshake logic SHALL reside in dot9_feeder.

Verification
REQ-042 9 pairs with A(k+1)=B(k+1)=0x3F800000 (1.0), then C=0x40000000 and rnd=2'b01, op_ready held 1 -> op_valid for exactly 1 cycle, with op_a/op_b all slots 0x3F800000, op_c=0x40000000, op_rnd=01 and op_count=9.
REQ-043 3 pairs with in_last on beat 3, then C -> slots 3..8 are 0x00000000 in both op_a and op_b, and op_count=3.
REQ-044 Full set loaded with op_ready held 0 for 5 cycles -> op_valid held 1, outputs stable and in_ready=0 throughout; the set is consumed on the cycle op_ready goes to 1.
REQ-045 flush after 4 pairs, then a new 9-pair set -> output contains only the new set and op_count=9.
REQ-046 rst asserted while in ISSUE -> next cycle op_valid=0, all op_* outputs 0 and in_ready=1.
REQ-047 in_valid toggled randomly during load -> slot order is preserved and no beats are lost or duplicated.
